// File: rtl/dsp_result_streamer_if.sv
// rtl/dsp_result_streamer_if.sv - byte stream bundle for the DSP result streamer
// Purpose : groups the outgoing byte stream and its flow-control signal.
// Signals : out_data  [7:0] current stream byte (master -> slave)
//           out_valid       out_data valid      (master -> slave)
//           out_ready       sink accepts byte   (slave -> master)
interface dsp_result_streamer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dsp_result_streamer.sv
// rtl/dsp_result_streamer.sv - snapshots DSP product words and streams them as a byte frame
// Purpose : on start, captures NUM_PROD 64-bit products and sends a frame
//           HDR_BYTE, product bytes (word 0 first, LSB byte first) and,
//           with macro DSP_STREAM_CHECKSUM_EN defined, an XOR checksum byte.
// Ports   : clk      sole clock, rising edge
//           reset    synchronous active-high reset
//           products NUM_PROD*64 product words, word k at [64k+63:64k]
//           start    snapshot-and-send request (ignored while busy)
//           busy     high from snapshot until the frame completes
//           done     one-cycle pulse after the last byte is accepted
//           stream   master side of the byte stream (out_data/out_valid/out_ready)
module dsp_result_streamer #(
   parameter int          NUM_PROD = 5,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PROD*64-1:0]  products,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   dsp_result_streamer_if.master   stream
);

   localparam int         NUM_BYTES = NUM_PROD * 8;
   localparam logic [5:0] LAST_IDX  = 6'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef DSP_STREAM_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_t;

   state_t                  r_state;
   logic [NUM_PROD*64-1:0]  r_snap;
   logic [5:0]              r_idx;
   logic [7:0]              r_out_data;
   logic                    r_out_valid;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_xfer;
   logic                    w_last;
   logic [5:0]              w_next_idx;
   logic [7:0]              w_next_byte;

   assign w_xfer      = r_out_valid & stream.out_ready;
   assign w_last      = (r_idx == LAST_IDX);
   assign w_next_idx  = r_idx + 6'd1;
   // Byte n of the snapshot sits at bit offset 8*n; only the low byte of the shift is kept.
   assign w_next_byte = 8'(r_snap >> {w_next_idx, 3'b000});

`ifdef DSP_STREAM_CHECKSUM_EN
   logic [7:0] r_csum;
   logic [7:0] w_csum_next;
   assign w_csum_next = r_csum ^ r_out_data;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_snap      <= '0;
         r_idx       <= 6'd0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef DSP_STREAM_CHECKSUM_EN
         r_csum      <= 8'h00;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_snap      <= products;
                  r_idx       <= 6'd0;
                  r_busy      <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_out_data  <= HDR_BYTE;
`ifdef DSP_STREAM_CHECKSUM_EN
                  r_csum      <= 8'h00;
`endif
                  r_state     <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_out_data <= r_snap[7:0];
                  r_idx      <= 6'd0;
                  r_state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  if (w_last) begin
`ifdef DSP_STREAM_CHECKSUM_EN
                     r_csum      <= w_csum_next;
                     r_out_data  <= w_csum_next;
                     r_state     <= S_CSUM;
`else
                     r_out_valid <= 1'b0;
                     r_out_data  <= 8'h00;
                     r_done      <= 1'b1;
                     r_state     <= S_FIN;
`endif
                  end else begin
`ifdef DSP_STREAM_CHECKSUM_EN
                     r_csum      <= w_csum_next;
`endif
                     r_idx       <= w_next_idx;
                     r_out_data  <= w_next_byte;
                  end
               end
            end
`ifdef DSP_STREAM_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_out_valid <= 1'b0;
                  r_out_data  <= 8'h00;
                  r_done      <= 1'b1;
                  r_state     <= S_FIN;
               end
            end
`endif
            S_FIN: begin
               // busy is held through the done cycle so a start here is ignored.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign stream.out_data  = r_out_data;
   assign stream.out_valid = r_out_valid;

endmodule
